// File: rtl/addsub_share_ctrl_if.sv
// rtl/addsub_share_ctrl_if.sv - requester and shared add/sub bus bundle for addsub_share_ctrl
//
// Purpose: groups both requester channels and the shared 4-bit adder/subtractor
// connection into one bundle.
//   slave  : controller view (requests and adder results in; grants, results,
//            adder operands out)
//   master : requester/adder view (the opposite directions)
// Optional macro ADDSUB_SHARE_OVF_EN adds the per-requester ovf0/ovf1 flags.
interface addsub_share_ctrl_if;
  logic       req0, req1;
  logic       op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1;
  logic       done0, done1;
  logic [3:0] res0, res1;
  logic       cout0, cout1;
  logic       busy;
  logic [3:0] adder_a, adder_b;
  logic       adder_select;
  logic [3:0] adder_sum;
  logic       adder_cout;
`ifdef ADDSUB_SHARE_OVF_EN
  logic       ovf0, ovf1;
`endif

  modport slave (
`ifdef ADDSUB_SHARE_OVF_EN
    output ovf0, ovf1,
`endif
    input  req0, req1, op0, op1, a0, b0, a1, b1, adder_sum, adder_cout,
    output gnt0, gnt1, done0, done1, res0, res1, cout0, cout1, busy,
    output adder_a, adder_b, adder_select
  );

  modport master (
`ifdef ADDSUB_SHARE_OVF_EN
    input  ovf0, ovf1,
`endif
    output req0, req1, op0, op1, a0, b0, a1, b1, adder_sum, adder_cout,
    input  gnt0, gnt1, done0, done1, res0, res1, cout0, cout1, busy,
    input  adder_a, adder_b, adder_select
  );
endinterface

// File: rtl/addsub_share_ctrl.sv
// rtl/addsub_share_ctrl.sv - round-robin time-sharing controller for one 4-bit add/sub unit
//
// Purpose: arbitrates two operand requesters onto a single shared adder/subtractor,
// holds the adder inputs stable for SETTLE_CYCLES cycles, then captures sum and
// carry into the owner's result register with a one-cycle done pulse.
// Parameters: SETTLE_CYCLES (1..15) cycles the adder inputs are held before capture.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : addsub_share_ctrl_if.slave
//                req/op/a/b per requester in, gnt/done/res/cout per requester out,
//                busy out, adder_a/adder_b/adder_select out, adder_sum/adder_cout in
// Optional macro ADDSUB_SHARE_OVF_EN: adds signed-overflow flags ovf0/ovf1,
// captured together with the result.
module addsub_share_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_share_ctrl_if.slave   bus
);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t     state, state_nx;
  logic [3:0] count, count_nx;
  logic       last;
  logic       owner;
  logic       eff0, eff1;
  logic       pick1;
  logic       grant;
  logic       capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    grant    = 1'b0;
    capture  = 1'b0;
    // A requester still holding req in its own done cycle only competes when
    // the other side is not asking; this keeps the partner from being starved.
    eff0  = bus.req0 & ~(bus.done0 & bus.req1);
    eff1  = bus.req1 & ~(bus.done1 & bus.req0);
    // On a tie, the requester not served last wins (last = 1 favours req0).
    pick1 = eff1 & (~eff0 | ~last);
    case (state)
      IDLE: begin
        if (eff0 | eff1) begin
          grant    = 1'b1;
          state_nx = SETTLE;
          count_nx = 4'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (count != 4'd0) begin
          count_nx = count - 4'd1;
        end else begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last             <= 1'b1;
      owner            <= 1'b0;
      bus.gnt0         <= 1'b0;
      bus.gnt1         <= 1'b0;
      bus.done0        <= 1'b0;
      bus.done1        <= 1'b0;
      bus.res0         <= 4'd0;
      bus.res1         <= 4'd0;
      bus.cout0        <= 1'b0;
      bus.cout1        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.adder_a      <= 4'd0;
      bus.adder_b      <= 4'd0;
      bus.adder_select <= 1'b0;
`ifdef ADDSUB_SHARE_OVF_EN
      bus.ovf0         <= 1'b0;
      bus.ovf1         <= 1'b0;
`endif
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      if (grant) begin
        // Operands are latched here so later changes on a/b/op cannot disturb
        // the operation in flight.
        owner            <= pick1;
        bus.adder_a      <= pick1 ? bus.a1  : bus.a0;
        bus.adder_b      <= pick1 ? bus.b1  : bus.b0;
        bus.adder_select <= pick1 ? bus.op1 : bus.op0;
        bus.gnt0         <= ~pick1;
        bus.gnt1         <= pick1;
        bus.busy         <= 1'b1;
      end
      if (capture) begin
        bus.gnt0 <= 1'b0;
        bus.gnt1 <= 1'b0;
        bus.busy <= 1'b0;
        last     <= owner;
        if (owner) begin
          bus.res1  <= bus.adder_sum;
          bus.cout1 <= bus.adder_cout;
          bus.done1 <= 1'b1;
`ifdef ADDSUB_SHARE_OVF_EN
          bus.ovf1  <= (bus.adder_a[3] ~^ (bus.adder_b[3] ^ bus.adder_select)) &
                       (bus.adder_sum[3] ^ bus.adder_a[3]);
`endif
        end else begin
          bus.res0  <= bus.adder_sum;
          bus.cout0 <= bus.adder_cout;
          bus.done0 <= 1'b1;
`ifdef ADDSUB_SHARE_OVF_EN
          bus.ovf0  <= (bus.adder_a[3] ~^ (bus.adder_b[3] ^ bus.adder_select)) &
                       (bus.adder_sum[3] ^ bus.adder_a[3]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// tb/tb_addsub_share_ctrl.sv - scoreboard bench for addsub_share_ctrl
module tb_addsub_share_ctrl;
  localparam int SETTLE = 2;

  typedef struct packed {
    logic [3:0] res;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_share_ctrl_if bus();

  addsub_share_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared adder/subtractor: A + B, or A + ~B + 1 when select is high.
  logic [4:0] adder_full;
  assign adder_full = {1'b0, bus.adder_a}
                    + {1'b0, (bus.adder_select ? ~bus.adder_b : bus.adder_b)}
                    + {4'b0000, bus.adder_select};
  assign bus.adder_sum  = adder_full[3:0];
  assign bus.adder_cout = adder_full[4];

  exp_t q0[$];
  exp_t q1[$];
  int   order_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    logic [31:0] v;
    v = '0;
    v[23:0] = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.res0, bus.res1,
               bus.cout0, bus.cout1, bus.busy, bus.adder_a, bus.adder_b,
               bus.adder_select};
`ifdef ADDSUB_SHARE_OVF_EN
    v[25:24] = {bus.ovf0, bus.ovf1};
`endif
    return v;
  endfunction

  task automatic on_done(input int id, input logic [3:0] res, input logic cout,
                         input logic ovf, input logic gnt, input logic prev_done,
                         input int gcyc);
    exp_t e;
    if (order_q.size() == 0) check("order_underflow", 1, 0);
    else check("done_order", id, order_q.pop_front());
    if (id == 0) begin
      if (q0.size() == 0) begin check("sb0_underflow", 1, 0); return; end
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) begin check("sb1_underflow", 1, 0); return; end
      e = q1.pop_front();
    end
    check(id == 0 ? "res0" : "res1", res, e.res);
    check(id == 0 ? "cout0" : "cout1", cout, e.cout);
`ifdef ADDSUB_SHARE_OVF_EN
    check(id == 0 ? "ovf0" : "ovf1", ovf, e.ovf);
`endif
    check("gnt_to_done_latency", cyc - gcyc, SETTLE);
    check("gnt_during_done", gnt, 0);
    check("done_single_cycle", prev_done, 0);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each done.
  initial begin
    int   gcyc0 = 0;
    int   gcyc1 = 0;
    logic pg0 = 1'b0, pg1 = 1'b0, pd0 = 1'b0, pd1 = 1'b0;
    logic o0, o1;
    forever begin
      @(negedge clk);
      cyc++;
      o0 = 1'b0;
      o1 = 1'b0;
`ifdef ADDSUB_SHARE_OVF_EN
      o0 = bus.ovf0;
      o1 = bus.ovf1;
`endif
      if (rst_n) begin
        if (bus.gnt0 && !pg0) gcyc0 = cyc;
        if (bus.gnt1 && !pg1) gcyc1 = cyc;
        check("gnt_excl_busy", {bus.gnt0 & bus.gnt1, bus.busy ^ (bus.gnt0 | bus.gnt1)}, 0);
        if (bus.done0) on_done(0, bus.res0, bus.cout0, o0, bus.gnt0, pd0, gcyc0);
        if (bus.done1) on_done(1, bus.res1, bus.cout1, o1, bus.gnt1, pd1, gcyc1);
      end
      pg0 = bus.gnt0;
      pg1 = bus.gnt1;
      pd0 = bus.done0;
      pd1 = bus.done1;
    end
  end

  task automatic set_req(input int id, input logic op, input logic [3:0] a,
                         input logic [3:0] b, input exp_t e);
    if (id == 0) begin
      q0.push_back(e);
      bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    end else begin
      q1.push_back(e);
      bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    end
  endtask

  // Returns the number of falling edges waited until the requester's done.
  task automatic wait_done(input int id, input int budget, output int waited);
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited++;
      if ((id == 0) ? bus.done0 : bus.done1) return;
    end
    check(id == 0 ? "timeout_done0" : "timeout_done1", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.a0 = 4'd0; bus.b0 = 4'd0; bus.a1 = 4'd0; bus.b1 = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0001 + 0001
    order_q.push_back(0);
    set_req(0, 1'b0, 4'b0001, 4'b0001, '{4'b0010, 1'b0, 1'b0});
    wait_done(0, 20, n);
    check("first_op_edges_to_done", n, SETTLE + 1);
    bus.req0 = 1'b0;
    @(negedge clk);

    // 1111 + 1111
    order_q.push_back(1);
    set_req(1, 1'b0, 4'b1111, 4'b1111, '{4'b1110, 1'b1, 1'b0});
    wait_done(1, 20, n);
    bus.req1 = 1'b0;
    @(negedge clk);

    // 0011 - 1010: 3 - (-6) leaves the signed range
    order_q.push_back(1);
    set_req(1, 1'b1, 4'b0011, 4'b1010, '{4'b1001, 1'b0, 1'b1});
    wait_done(1, 20, n);
    bus.req1 = 1'b0;
    @(negedge clk);

    // Simultaneous requests after reset, both held: strict alternation.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    order_q.push_back(0); order_q.push_back(1);
    order_q.push_back(0); order_q.push_back(1);
    fork
      begin
        int w;
        set_req(0, 1'b0, 4'b0101, 4'b0010, '{4'b0111, 1'b0, 1'b0});
        wait_done(0, 30, w);
        set_req(0, 1'b1, 4'b0000, 4'b0001, '{4'b1111, 1'b0, 1'b0});
        wait_done(0, 30, w);
        bus.req0 = 1'b0;
      end
      begin
        int w;
        set_req(1, 1'b1, 4'b0111, 4'b0001, '{4'b0110, 1'b1, 1'b0});
        wait_done(1, 30, w);
        set_req(1, 1'b0, 4'b0100, 4'b0100, '{4'b1000, 1'b0, 1'b1});
        wait_done(1, 30, w);
        bus.req1 = 1'b0;
      end
    join
    @(negedge clk);

    // Sole requester holding req0: one operation every SETTLE+1 cycles.
    order_q.push_back(0); order_q.push_back(0); order_q.push_back(0);
    set_req(0, 1'b0, 4'b0001, 4'b0010, '{4'b0011, 1'b0, 1'b0});
    wait_done(0, 20, n);
    set_req(0, 1'b0, 4'b1000, 4'b1000, '{4'b0000, 1'b1, 1'b1});
    wait_done(0, 20, n);
    check("b2b_period_1", n, SETTLE + 1);
    set_req(0, 1'b1, 4'b1001, 4'b0001, '{4'b1000, 1'b1, 1'b0});
    wait_done(0, 20, n);
    check("b2b_period_2", n, SETTLE + 1);
    bus.req0 = 1'b0;
    @(negedge clk);

    // Operand change after grant must not affect the result.
    order_q.push_back(0);
    set_req(0, 1'b1, 4'b0011, 4'b1010, '{4'b1001, 1'b0, 1'b1});
    @(negedge clk);
    check("midop_gnt0", bus.gnt0, 1);
    bus.a0 = 4'b1011;
    wait_done(0, 20, n);
    bus.req0 = 1'b0;
    @(negedge clk);

    // Reset during SETTLE: everything clears, no done for the aborted op.
    bus.op0 = 1'b0; bus.a0 = 4'b0010; bus.b0 = 4'b0011; bus.req0 = 1'b1;
    @(negedge clk);
    check("abort_gnt0", bus.gnt0, 1);
    rst_n = 1'b0;
    #1;
    check("abort_reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    check("abort_no_done", {bus.done0, bus.done1}, 0);
    order_q.push_back(0);
    q0.push_back('{4'b0101, 1'b0, 1'b0});
    rst_n = 1'b1;
    wait_done(0, 20, n);
    bus.req0 = 1'b0;
    repeat (4) @(negedge clk);

    check("scoreboard_drained", q0.size() + q1.size() + order_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
